// File: rtl/multicycle_adder_pkg.sv
// multicycle_adder_pkg
//   Shared definitions for the digit-serial adder/subtractor.
//   - state_t   : FSM encoding (IDLE, RUN, DONE), 2-bit state register.
//   - cnt_width : width of the digit counter, clog2(n) with a floor of 1.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter runs 0..n-1. For n <= 2 this needs one bit, which is
    // also the floor for n = 1 (where $clog2 would return 0).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multicycle_adder_slice_adder.sv
// slice_adder
//   Combinational ripple of DIGIT full-adder cells. This is the narrow slice
//   that the top level time-multiplexes across the operand.
//   Ports:
//     a, b   in  [DIGIT-1:0]  slice operands
//     cin    in  1            carry into bit 0
//     sum    out [DIGIT-1:0]  slice sum
//     cout   out 1            carry out of bit DIGIT-1
//     c_msb  out 1            carry into bit DIGIT-1 (for signed overflow)
module slice_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin : ripple
        // Carry chain is kept local to the block so each bit is a clean
        // function of the bit below it.
        logic [DIGIT:0] c;
        // NOTE: every variable written here gets a value before any branch
        // or loop, so no path can leave it unassigned and infer a latch.
        c     = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Digit-serial adder/subtractor: processes DIGIT bits per clock using a
//   registered carry, N = WIDTH/DIGIT clocks per operation.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/in_ready operand handshake (in_ready high only in IDLE)
//     a, b [WIDTH]      operands, sampled on the accept edge
//     cin               carry-in, ignored when sub = 1
//     sub               0: a + b + cin, 1: a - b (as a + ~b + 1)
//     out_valid/out_ready result handshake (out_valid high only in DONE)
//     sum [WIDTH]       result modulo 2^WIDTH, held after the handshake
//     cout              carry out of MSB (sub: 1 = no borrow)
//     ovf               two's-complement overflow
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_sh, b_sh, res_sh, res_next;
    logic              carry, cout_r, ovf_r;
    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout, slice_cmsb;
    logic              last;

    slice_adder #(.DIGIT(DIGIT)) u_slice (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    assign last = (cnt == CW'(N - 1));

    // Result fills from the top: after N slices the first slice has been
    // pushed down to bit 0. With a single slice there is nothing to shift.
    if (N == 1) begin : g_res_one
        assign res_next = slice_sum;
    end else begin : g_res_shift
        assign res_next = {slice_sum, res_sh[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last)     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand shift registers are reset along with the visible
        // result so an aborted operation leaves no stale data behind.
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= sub ? ~b : b;
                    carry <= sub ? 1'b1 : cin;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    carry  <= slice_cout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        cout_r <= slice_cout;
                        ovf_r  <= slice_cout ^ slice_cmsb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = res_sh;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder
//   Four instances share one clock and reset:
//     0: WIDTH=8  DIGIT=2   1: WIDTH=8 DIGIT=8
//     2: WIDTH=8  DIGIT=1   3: WIDTH=32 DIGIT=4
//   Expected results are computed by a behavioural model, pushed to a
//   scoreboard queue at the accept edge and popped when out_valid appears.
module tb_multicycle_adder;

    typedef struct {
        int          idx;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic        cin       [4];
    logic        sub       [4];
    logic [31:0] a         [4];
    logic [31:0] b         [4];
    wire         in_ready  [4];
    wire         out_valid [4];
    wire         cout      [4];
    wire         ovf       [4];
    wire  [31:0] sum       [4];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][7:0]), .b(b[0][7:0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum[0][7:0]), .cout(cout[0]), .ovf(ovf[0]));
    multicycle_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][7:0]), .b(b[1][7:0]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum[1][7:0]), .cout(cout[1]), .ovf(ovf[1]));
    multicycle_adder #(.WIDTH(8), .DIGIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2][7:0]), .b(b[2][7:0]), .cin(cin[2]), .sub(sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum[2][7:0]), .cout(cout[2]), .ovf(ovf[2]));
    multicycle_adder #(.WIDTH(32), .DIGIT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a[3]), .b(b[3]), .cin(cin[3]), .sub(sub[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .sum(sum[3]), .cout(cout[3]), .ovf(ovf[3]));

    assign sum[0][31:8] = '0;
    assign sum[1][31:8] = '0;
    assign sum[2][31:8] = '0;

    function automatic int width_of(input int idx);
        return (idx == 3) ? 32 : 8;
    endfunction

    function automatic int lat_of(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 8;
        endcase
    endfunction

    // Reference: full-width add, overflow from operand/result signs.
    function automatic exp_t model(input int idx, input logic [31:0] aa, input logic [31:0] bb,
                                   input logic ci, input logic sb_);
        exp_t        e;
        int          w;
        logic [31:0] mask, bm, am;
        logic [32:0] full;
        w    = width_of(idx);
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = aa & mask;
        bm   = (sb_ ? ~bb : bb) & mask;
        full = {1'b0, am} + {1'b0, bm} + {32'h0, (sb_ ? 1'b1 : ci)};
        e.idx  = idx;
        e.sum  = full[31:0] & mask;
        e.cout = full[w];
        e.ovf  = (am[w-1] == bm[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the instance idle; returns at the negedge
    // following the accept edge.
    task automatic start_op(input int idx, input logic [31:0] aa, input logic [31:0] bb,
                            input logic ci, input logic sb_);
        check("in_ready_idle", 64'(in_ready[idx]), 64'd1);
        a[idx]        = aa;
        b[idx]        = bb;
        cin[idx]      = ci;
        sub[idx]      = sb_;
        in_valid[idx] = 1'b1;
        sb.push_back(model(idx, aa, bb, ci, sb_));
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        // Operands must not matter after the accept edge.
        a[idx]   = $urandom;
        b[idx]   = $urandom;
        cin[idx] = 1'($urandom);
        sub[idx] = 1'($urandom);
    endtask

    // Waits for the result, compares it, holds off out_ready for 'stall'
    // cycles (optionally pulsing in_valid), then completes the handshake.
    task automatic finish_op(input int idx, input int stall, input bit pulse);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!out_valid[idx] && cycles < 64) begin
            check("in_ready_busy", 64'(in_ready[idx]), 64'd0);
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        if (!out_valid[idx]) begin
            check("out_valid_timeout", 64'(out_valid[idx]), 64'd1);
            void'(sb.pop_front());
            return;
        end
        check("latency", 64'(cycles), 64'(lat_of(idx)));
        e = sb.pop_front();
        check("sum",  64'(sum[idx]),  64'(e.sum));
        check("cout", 64'(cout[idx]), 64'(e.cout));
        check("ovf",  64'(ovf[idx]),  64'(e.ovf));
        for (int s = 0; s < stall; s++) begin
            in_valid[idx] = pulse && (s == 3);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(out_valid[idx]), 64'd1);
            check("hold_ready", 64'(in_ready[idx]),  64'd0);
            check("hold_sum",   64'(sum[idx]),       64'(e.sum));
            check("hold_flags", {62'd0, cout[idx], ovf[idx]}, {62'd0, e.cout, e.ovf});
        end
        in_valid[idx]  = 1'b0;
        out_ready[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[idx] = 1'b0;
        check("post_valid", 64'(out_valid[idx]), 64'd0);
        check("post_ready", 64'(in_ready[idx]),  64'd1);
        check("post_sum",   64'(sum[idx]),       64'(e.sum));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b0;
            cin[i] = 1'b0; sub[i] = 1'b0; a[i] = '0; b[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_in_ready",  64'(in_ready[i]),  64'd1);
            check("rst_out_valid", 64'(out_valid[i]), 64'd0);
            check("rst_sum",       64'(sum[i]),       64'd0);
            check("rst_flags",     {62'd0, cout[i], ovf[i]}, 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // WIDTH=8, DIGIT=2 directed cases.
        start_op(0, 32'hFF, 32'h01, 1'b0, 1'b0); finish_op(0, 0, 1'b0);
        start_op(0, 32'h7F, 32'h01, 1'b0, 1'b0); finish_op(0, 0, 1'b0);
        start_op(0, 32'h05, 32'h07, 1'b0, 1'b1); finish_op(0, 0, 1'b0);
        start_op(0, 32'h05, 32'h07, 1'b1, 1'b1); finish_op(0, 0, 1'b0);
        start_op(0, 32'h80, 32'h01, 1'b0, 1'b1); finish_op(0, 0, 1'b0);
        start_op(0, 32'h3C, 32'h55, 1'b1, 1'b0); finish_op(0, 1, 1'b0);

        // Backpressure with an in_valid pulse during DONE.
        start_op(0, 32'hA5, 32'h5A, 1'b1, 1'b0); finish_op(0, 10, 1'b1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("no_spurious_op", {62'd0, in_ready[0], out_valid[0]}, 64'd2);
        end

        // Reset in the second RUN cycle aborts the operation.
        start_op(0, 32'hC3, 32'h11, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid[0]), 64'd0);
        check("abort_sum",   64'(sum[0]),       64'd0);
        check("abort_ready", 64'(in_ready[0]),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", 64'(in_ready[0]),  64'd1);
        check("after_rst_valid", 64'(out_valid[0]), 64'd0);
        start_op(0, 32'h10, 32'h20, 1'b0, 1'b0); finish_op(0, 0, 1'b0);

        // Degenerate digit widths.
        start_op(1, 32'h80, 32'h80, 1'b0, 1'b0); finish_op(1, 0, 1'b0);
        start_op(1, 32'h12, 32'h34, 1'b0, 1'b1); finish_op(1, 2, 1'b0);
        start_op(2, 32'h80, 32'h80, 1'b0, 1'b0); finish_op(2, 0, 1'b0);
        start_op(2, 32'h7F, 32'h80, 1'b0, 1'b1); finish_op(2, 0, 1'b0);

        // Random regression on the 32/4 instance.
        for (int i = 0; i < 1000; i++) begin
            start_op(3, $urandom, $urandom, 1'($urandom), 1'($urandom));
            finish_op(3, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b0);
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
